// File: rtl/delay_pkg.sv
// delay_pkg: shared defaults and helpers for the delay_line block.
//   DEF_DATA_W / DEF_MAX_DEPTH / DEF_N_CH / DEF_FLAG_INIT : parameter defaults
//   depth_clamp()                                         : maps a requested
//                                                           depth onto 1..max
package delay_pkg;

   localparam int unsigned DEF_DATA_W    = 16;
   localparam int unsigned DEF_MAX_DEPTH = 16;
   localparam int unsigned DEF_N_CH      = 2;
   localparam bit          DEF_FLAG_INIT = 1'b1;

   // A depth of 0 would select no tap at all, so it is treated as 1.
   function automatic int unsigned depth_clamp(input int unsigned depth,
                                               input int unsigned max_depth);
      if (depth == 0)
         return 1;
      else if (depth > max_depth)
         return max_depth;
      else
         return depth;
   endfunction

endpackage

// File: rtl/delay_line_if.sv
// delay_line_if: control/data bundle of the delay line.
//   en, flush, depth, data_in, flag_in : driven by the master (user logic)
//   data_out, flag_out, primed         : driven by the slave (delay_line)
interface delay_line_if
   import delay_pkg::*;
#(
   parameter int unsigned DATA_W    = DEF_DATA_W,
   parameter int unsigned MAX_DEPTH = DEF_MAX_DEPTH,
   parameter int unsigned N_CH      = DEF_N_CH
) ();

   localparam int unsigned DEPTH_W = $clog2(MAX_DEPTH + 1);

   logic               en;
   logic               flush;
   logic [DEPTH_W-1:0] depth;
   logic [DATA_W-1:0]  data_in;
   logic [N_CH-1:0]    flag_in;
   logic [DATA_W-1:0]  data_out;
   logic [N_CH-1:0]    flag_out;
   logic               primed;

   modport master (
      output en, flush, depth, data_in, flag_in,
      input  data_out, flag_out, primed
   );

   modport slave (
      input  en, flush, depth, data_in, flag_in,
      output data_out, flag_out, primed
   );

endinterface

// File: rtl/delay_tap_chain.sv
// delay_tap_chain: MAX_DEPTH-stage shift register of W-bit words.
//   clk, rst : clock, asynchronous active-high reset
//   en       : shift enable (0 holds every stage)
//   flush    : synchronous clear of every stage, wins over en
//   d_i      : word entering stage 0
//   taps_o   : all stage contents, taps_o[0] is the newest sample
module delay_tap_chain #(
   parameter int unsigned W         = 18,
   parameter int unsigned MAX_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   input  logic                          flush,
   input  logic [W-1:0]                  d_i,
   output logic [MAX_DEPTH-1:0][W-1:0]   taps_o
);

   for (genvar gi = 0; gi < MAX_DEPTH; gi++) begin : g_stage
      logic [W-1:0] tap_q;
      logic [W-1:0] tap_src;

      if (gi == 0) begin : g_head
         assign tap_src = d_i;
      end else begin : g_body
         assign tap_src = g_stage[gi-1].tap_q;
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst)
            tap_q <= '0;
         else if (flush)
            tap_q <= '0;
         else if (en)
            tap_q <= tap_src;
      end

      assign taps_o[gi] = tap_q;
   end

endmodule

// File: rtl/delay_line.sv
// delay_line: programmable delay of a data word plus N_CH flag bits.
//   clk, rst        : clock, asynchronous active-high reset
//   bus.en          : shift enable; 0 freezes taps, counter and primed
//   bus.flush       : synchronous clear of taps and priming
//   bus.depth       : requested delay, clamped to 1..MAX_DEPTH
//   bus.data_in     : data sample          bus.flag_in  : flag samples
//   bus.data_out    : delayed data (never masked)
//   bus.flag_out    : delayed flags, FLAG_INIT on every bit until primed
//   bus.primed      : the line holds depth_eff samples since last restart
module delay_line
   import delay_pkg::*;
#(
   parameter int unsigned DATA_W    = DEF_DATA_W,
   parameter int unsigned MAX_DEPTH = DEF_MAX_DEPTH,
   parameter int unsigned N_CH      = DEF_N_CH,
   parameter bit          FLAG_INIT = DEF_FLAG_INIT
) (
   input  logic         clk,
   input  logic         rst,
   delay_line_if.slave  bus
);

   localparam int unsigned DEPTH_W = $clog2(MAX_DEPTH + 1);
   localparam int unsigned W       = DATA_W + N_CH;

   logic [DEPTH_W-1:0]          depth_req;
   logic [DEPTH_W-1:0]          depth_q, depth_d;
   logic [DEPTH_W-1:0]          cnt_q, cnt_d;
   logic                        primed_q, primed_d;
   logic                        depth_chg;
   logic [MAX_DEPTH-1:0][W-1:0] taps;
   logic [W-1:0]                tap_sel;

   // Flags travel in the upper bits of the same chain as the data.
   delay_tap_chain #(
      .W         (W),
      .MAX_DEPTH (MAX_DEPTH)
   ) u_chain (
      .clk    (clk),
      .rst    (rst),
      .en     (bus.en),
      .flush  (bus.flush),
      .d_i    ({bus.flag_in, bus.data_in}),
      .taps_o (taps)
   );

   assign depth_req = DEPTH_W'(depth_clamp(32'(bus.depth), MAX_DEPTH));
   assign depth_chg = (depth_req != depth_q);

   // The depth register tracks the request on every edge; a change restarts
   // priming (counting the current sample if it is being shifted in) but
   // leaves the taps untouched.
   always_comb begin
      depth_d = depth_req;
      cnt_d   = cnt_q;
      if (bus.flush)
         cnt_d = '0;
      else if (depth_chg)
         cnt_d = bus.en ? DEPTH_W'(1) : '0;
      else if (bus.en && (cnt_q != depth_q))
         cnt_d = cnt_q + DEPTH_W'(1);
      primed_d = (cnt_d == depth_d);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         depth_q  <= DEPTH_W'(1);
         cnt_q    <= '0;
         primed_q <= 1'b0;
      end else begin
         depth_q  <= depth_d;
         cnt_q    <= cnt_d;
         primed_q <= primed_d;
      end
   end

   // Single MAX_DEPTH:1 mux choosing tap[depth_q-1]; driven only by
   // registers so the outputs cannot glitch on input activity.
   always_comb begin
      tap_sel = '0;
      for (int i = 0; i < MAX_DEPTH; i++) begin
         if (depth_q == DEPTH_W'(i + 1))
            tap_sel = taps[i];
      end
   end

   assign bus.data_out = tap_sel[DATA_W-1:0];
   assign bus.flag_out = primed_q ? tap_sel[W-1:DATA_W] : {N_CH{FLAG_INIT}};
   assign bus.primed   = primed_q;

endmodule

// File: tb/tb_delay_line.sv
module tb_delay_line;

   localparam int DATA_W    = 16;
   localparam int MAX_DEPTH = 16;
   localparam int N_CH      = 2;
   localparam int DEPTH_W   = $clog2(MAX_DEPTH + 1);
   localparam int W         = DATA_W + N_CH;

   logic clk = 1'b0;
   logic rst = 1'b1;

   delay_line_if #(.DATA_W(DATA_W), .MAX_DEPTH(MAX_DEPTH), .N_CH(N_CH)) bus_if ();

   delay_line #(
      .DATA_W    (DATA_W),
      .MAX_DEPTH (MAX_DEPTH),
      .N_CH      (N_CH),
      .FLAG_INIT (1'b1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   int cycle       = 0;

   // ---------------- behavioural model ----------------
   // Keeps the list of samples accepted since the last reset/flush; the
   // output is simply the sample accepted depth_eff enables ago.
   logic [W-1:0] hist[$];
   int           m_depth = 1;
   int           m_cnt   = 0;

   function automatic int clampd(input int d);
      if (d < 1) return 1;
      if (d > MAX_DEPTH) return MAX_DEPTH;
      return d;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         hist.delete();
         m_depth = 1;
         m_cnt   = 0;
      end else begin
         int nd;
         nd = clampd(int'(bus_if.depth));
         if (bus_if.flush) begin
            hist.delete();
            m_cnt = 0;
         end else begin
            if (bus_if.en) begin
               hist.push_back({bus_if.flag_in, bus_if.data_in});
               if (hist.size() > MAX_DEPTH) void'(hist.pop_front());
            end
            if (nd != m_depth)
               m_cnt = bus_if.en ? 1 : 0;
            else if (bus_if.en && m_cnt < nd)
               m_cnt = m_cnt + 1;
         end
         m_depth = nd;
      end
   end

   function automatic logic [W-1:0] m_sel();
      if (hist.size() >= m_depth) return hist[hist.size() - m_depth];
      return '0;
   endfunction

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      logic [W-1:0]      s;
      logic              ep;
      logic [N_CH-1:0]   ef;
      s  = m_sel();
      ep = (m_cnt == m_depth);
      ef = ep ? s[W-1:DATA_W] : {N_CH{1'b1}};
      vectors++;
      if (bus_if.data_out !== s[DATA_W-1:0] || bus_if.flag_out !== ef ||
          bus_if.primed !== ep) begin
         miscompares++;
         $display("FAIL model cyc %0d: data_out=%h flag_out=%b primed=%b, expected %h %b %b",
                  cycle, bus_if.data_out, bus_if.flag_out, bus_if.primed,
                  s[DATA_W-1:0], ef, ep);
      end else begin
         $display("cyc %0d ok: data_out=%h flag_out=%b primed=%b",
                  cycle, bus_if.data_out, bus_if.flag_out, bus_if.primed);
      end
      cycle++;
   end

   // ---------------- literal expectations ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("%s ok: %0h", name, act);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus_if.en      = 1'b0;
      bus_if.flush   = 1'b0;
      bus_if.depth   = DEPTH_W'(4);
      bus_if.data_in = '0;
      bus_if.flag_in = '0;
      #22;
      chk("reset data_out", 32'(bus_if.data_out), 32'h0);
      chk("reset flag_out", 32'(bus_if.flag_out), 32'h3);
      chk("reset primed",   32'(bus_if.primed),   32'h0);
      rst = 1'b0;
      step();

      // depth 4, incrementing data, flags held at 00
      bus_if.en = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         bus_if.data_in = DATA_W'(k);
         bus_if.flag_in = '0;
         step();
         if (k == 3) begin
            chk("d4 edge3 data_out", 32'(bus_if.data_out), 32'h0);
            chk("d4 edge3 primed",   32'(bus_if.primed),   32'h0);
            chk("d4 edge3 flag_out", 32'(bus_if.flag_out), 32'h3);
         end
         if (k == 4) begin
            chk("d4 edge4 data_out", 32'(bus_if.data_out), 32'h1);
            chk("d4 edge4 primed",   32'(bus_if.primed),   32'h1);
            chk("d4 edge4 flag_out", 32'(bus_if.flag_out), 32'h0);
         end
      end
      chk("d4 edge6 data_out", 32'(bus_if.data_out), 32'h3);

      // switch to depth 2 while primed
      bus_if.depth   = DEPTH_W'(2);
      bus_if.data_in = DATA_W'(7);
      step();
      chk("d2 switch data_out", 32'(bus_if.data_out), 32'h6);
      chk("d2 switch primed",   32'(bus_if.primed),   32'h0);
      bus_if.data_in = DATA_W'(8);
      step();
      chk("d2 reprime data_out", 32'(bus_if.data_out), 32'h7);
      chk("d2 reprime primed",   32'(bus_if.primed),   32'h1);

      // flush while primed
      bus_if.flush   = 1'b1;
      bus_if.data_in = DATA_W'(9);
      step();
      chk("flush data_out", 32'(bus_if.data_out), 32'h0);
      chk("flush primed",   32'(bus_if.primed),   32'h0);
      chk("flush flag_out", 32'(bus_if.flag_out), 32'h3);
      bus_if.flush = 1'b0;

      // depth 8 with en alternating
      bus_if.depth = DEPTH_W'(8);
      for (int i = 0; i < 16; i++) begin
         bus_if.en      = (i % 2 == 0);
         bus_if.data_in = DATA_W'(16'h100 + i);
         bus_if.flag_in = N_CH'(i + 1);
         step();
         if (i == 13) chk("d8 en-toggle i13 primed", 32'(bus_if.primed), 32'h0);
         if (i == 14) begin
            chk("d8 en-toggle i14 primed",   32'(bus_if.primed),   32'h1);
            chk("d8 en-toggle i14 data_out", 32'(bus_if.data_out), 32'h100);
            chk("d8 en-toggle i14 flag_out", 32'(bus_if.flag_out), 32'h1);
         end
      end

      // depth 0 behaves as 1
      bus_if.en      = 1'b1;
      bus_if.depth   = DEPTH_W'(0);
      bus_if.data_in = DATA_W'(16'h00AA);
      bus_if.flag_in = 2'b10;
      step();
      chk("d0 data_out", 32'(bus_if.data_out), 32'hAA);
      chk("d0 primed",   32'(bus_if.primed),   32'h1);
      chk("d0 flag_out", 32'(bus_if.flag_out), 32'h2);

      // depth 20 behaves as 16
      bus_if.depth = DEPTH_W'(20);
      for (int i = 0; i < 16; i++) begin
         bus_if.data_in = DATA_W'(16'h200 + i);
         bus_if.flag_in = N_CH'($urandom_range(3, 0));
         step();
         if (i == 14) chk("d20 i14 primed", 32'(bus_if.primed), 32'h0);
      end
      chk("d20 primed",   32'(bus_if.primed),   32'h1);
      chk("d20 data_out", 32'(bus_if.data_out), 32'h200);

      // asynchronous reset mid-stream
      bus_if.depth = DEPTH_W'(3);
      rst = 1'b1;
      #1;
      chk("midrst data_out", 32'(bus_if.data_out), 32'h0);
      chk("midrst flag_out", 32'(bus_if.flag_out), 32'h3);
      chk("midrst primed",   32'(bus_if.primed),   32'h0);
      step();
      step();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         bus_if.data_in = DATA_W'($urandom_range(16'hFFFF, 0));
         bus_if.flag_in = N_CH'($urandom_range(3, 0));
         step();
         if (i == 1) chk("post-rst i1 primed", 32'(bus_if.primed), 32'h0);
         if (i == 2) chk("post-rst i2 primed", 32'(bus_if.primed), 32'h1);
      end

      // en low holds everything
      bus_if.en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus_if.data_in = DATA_W'(16'hDEAD);
         step();
      end

      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
